// File: rtl/stopwatch_controller.sv
// Stopwatch control: 100 Hz tick detection, pushbutton debouncing, start/stop/lap/reset
// sequencing and an MM:SS.cc BCD time base driving six seven-segment digits.
module stopwatch_controller #(
    parameter int DEBOUNCE_TICKS = 2,
    parameter int MAX_MINUTES    = 59
) (
    input  logic        CLK_50_MHz,
    input  logic        reset_n,
    input  logic        CLK_100Hz,
    input  logic        key_start_stop_n,
    input  logic        key_lap_reset_n,
    output logic [23:0] disp_bcd,
    output logic        running,
    output logic        lap_active,
    output logic        overflow
);

    localparam int NUM_KEYS = 2;
    localparam logic [3:0] MAX_T   = 4'(MAX_MINUTES / 10);
    localparam logic [3:0] MAX_U   = 4'(MAX_MINUTES % 10);
    localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_TICKS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_RUN_LAP, S_PAUSED} state_t;

    // Asynchronous assert, synchronous release of the internal reset.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge CLK_50_MHz or negedge reset_n) begin
        if (!reset_n) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    logic r_clk_prev;
    logic w_tick;

    always_ff @(posedge CLK_50_MHz or negedge w_rst_n) begin
        if (!w_rst_n) r_clk_prev <= 1'b0;
        else          r_clk_prev <= CLK_100Hz;
    end
    assign w_tick = CLK_100Hz & ~r_clk_prev;

    // Button lanes: index 0 = start/stop, index 1 = lap/reset.
    logic [NUM_KEYS-1:0] w_key_n;
    logic [NUM_KEYS-1:0] w_press;
    assign w_key_n = {key_lap_reset_n, key_start_stop_n};

    genvar g;
    generate
        for (g = 0; g < NUM_KEYS; g++) begin : g_key
            // Synchronizer and sample hold the pressed state active-high, so their
            // zero reset agrees with the released debounced level of 1.
            logic [1:0] r_sync;
            logic       r_sample;
            logic       r_level;
            logic [3:0] r_cnt;
            logic       r_press;
            logic       w_differ;

            assign w_differ = (r_sample == r_level);

            always_ff @(posedge CLK_50_MHz or negedge w_rst_n) begin
                if (!w_rst_n) begin
                    r_sync   <= 2'b00;
                    r_sample <= 1'b0;
                    r_level  <= 1'b1;
                    r_cnt    <= 4'd0;
                    r_press  <= 1'b0;
                end else begin
                    r_sync  <= {r_sync[0], ~w_key_n[g]};
                    r_press <= 1'b0;
                    if (w_tick) begin
                        r_sample <= r_sync[1];
                        if (!w_differ) begin
                            r_cnt <= 4'd0;
                        end else if (r_cnt == DB_LAST) begin
                            r_cnt   <= 4'd0;
                            r_level <= ~r_level;
                            r_press <= r_level;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                end
            end
            assign w_press[g] = r_press;
        end
    endgenerate

    logic w_ss;
    logic w_lr;
    assign w_ss = w_press[0];
    assign w_lr = w_press[1] & ~w_press[0];

    state_t r_state;

    always_ff @(posedge CLK_50_MHz or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state    <= S_IDLE;
            running    <= 1'b0;
            lap_active <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_ss) begin
                        r_state <= S_RUN;
                        running <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_ss) begin
                        r_state <= S_PAUSED;
                        running <= 1'b0;
                    end else if (w_lr) begin
                        r_state    <= S_RUN_LAP;
                        lap_active <= 1'b1;
                    end
                end
                S_RUN_LAP: begin
                    if (w_ss) begin
                        r_state    <= S_PAUSED;
                        running    <= 1'b0;
                        lap_active <= 1'b0;
                    end else if (w_lr) begin
                        r_state    <= S_RUN;
                        lap_active <= 1'b0;
                    end
                end
                S_PAUSED: begin
                    if (w_ss) begin
                        r_state <= S_RUN;
                        running <= 1'b1;
                    end else if (w_lr) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    running    <= 1'b0;
                    lap_active <= 1'b0;
                end
            endcase
        end
    end

    // Digits: [0]=cs_u [1]=cs_t [2]=sec_u [3]=sec_t [4]=min_u [5]=min_t.
    logic [5:0][3:0] r_time;
    logic [5:0][3:0] r_lap;
    logic [5:0][3:0] w_next;
    logic            w_wrap;
    logic            w_count;
    logic            w_clear;
    logic            w_c0, w_c1, w_c2, w_c3;

    assign w_count = w_tick & ((r_state == S_RUN) | (r_state == S_RUN_LAP));
    assign w_clear = w_lr & ((r_state == S_IDLE) | (r_state == S_PAUSED));

    assign w_c0 = (r_time[0] == 4'd9);
    assign w_c1 = w_c0 & (r_time[1] == 4'd9);
    assign w_c2 = w_c1 & (r_time[2] == 4'd9);
    assign w_c3 = w_c2 & (r_time[3] == 4'd5);

    always_comb begin
        w_next    = r_time;
        w_wrap    = 1'b0;
        w_next[0] = w_c0 ? 4'd0 : r_time[0] + 4'd1;
        if (w_c0) w_next[1] = (r_time[1] == 4'd9) ? 4'd0 : r_time[1] + 4'd1;
        if (w_c1) w_next[2] = (r_time[2] == 4'd9) ? 4'd0 : r_time[2] + 4'd1;
        if (w_c2) w_next[3] = (r_time[3] == 4'd5) ? 4'd0 : r_time[3] + 4'd1;
        if (w_c3) begin
            if (r_time[5] == MAX_T && r_time[4] == MAX_U) begin
                w_next[4] = 4'd0;
                w_next[5] = 4'd0;
                w_wrap    = 1'b1;
            end else if (r_time[4] == 4'd9) begin
                w_next[4] = 4'd0;
                w_next[5] = r_time[5] + 4'd1;
            end else begin
                w_next[4] = r_time[4] + 4'd1;
            end
        end
    end

    // Clear only fires in non-counting states, so it never races an increment.
    always_ff @(posedge CLK_50_MHz or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_time   <= '0;
            r_lap    <= '0;
            overflow <= 1'b0;
        end else begin
            if (w_clear) begin
                r_time   <= '0;
                overflow <= 1'b0;
            end else if (w_count) begin
                r_time <= w_next;
                if (w_wrap) overflow <= 1'b1;
            end
            if (r_state == S_RUN && w_lr) r_lap <= r_time;
        end
    end

    assign disp_bcd = lap_active ? r_lap : r_time;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Scoreboard bench for stopwatch_controller; one tick every two clocks keeps long runs short.
module tb_stopwatch_controller;

    localparam int D       = 2;
    localparam int MAXM    = 1;
    localparam int WRAP_CS = (MAXM + 1) * 6000;
    localparam int TICK_CYC = 2;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        clk100  = 1'b0;
    logic        ss_n    = 1'b1;
    logic        lr_n    = 1'b1;
    logic [23:0] disp;
    logic        running;
    logic        lap_active;
    logic        overflow;

    stopwatch_controller #(.DEBOUNCE_TICKS(D), .MAX_MINUTES(MAXM)) dut (
        .CLK_50_MHz       (clk),
        .reset_n          (rst_n),
        .CLK_100Hz        (clk100),
        .key_start_stop_n (ss_n),
        .key_lap_reset_n  (lr_n),
        .disp_bcd         (disp),
        .running          (running),
        .lap_active       (lap_active),
        .overflow         (overflow)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;

    int m_cs     = 0;
    bit m_ovf    = 1'b0;
    int m_lap    = 0;
    bit lap_seen = 1'b0;
    int t_run    = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] to_bcd(input int cs);
        int m, s, c;
        m = cs / 6000;
        s = (cs / 100) % 60;
        c = cs % 100;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    task automatic expect_st(input string tag, input bit ovf, input bit lap, input bit run,
                             input logic [23:0] d);
        exp_t e;
        e.tag = tag;
        e.val = {5'd0, ovf, lap, run, d};
        exp_q.push_back(e);
    endtask

    task automatic compare_outs();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.tag, {5'd0, overflow, lap_active, running, disp}, e.val);
        end
    endtask

    // Entered at a negedge; a tick counts when running is high just before its edge.
    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            if (running && t_run < 0) t_run = cyc;
            if (lap_active && !lap_seen) m_lap = m_cs;
            lap_seen = lap_active;
            if (running) begin
                m_cs++;
                if (m_cs == WRAP_CS) begin
                    m_cs  = 0;
                    m_ovf = 1'b1;
                end
            end
            clk100 = 1'b1;
            @(negedge clk);
            clk100 = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic press(input bit ss, input bit lr);
        if (ss) ss_n = 1'b0;
        if (lr) lr_n = 1'b0;
        do_ticks(D + 3);
        ss_n = 1'b1;
        lr_n = 1'b1;
        do_ticks(D + 4);
    endtask

    int t0;
    int saved;

    initial begin
        repeat (3) @(negedge clk);
        expect_st("reset", 0, 0, 0, 24'h000000);
        compare_outs();
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        expect_st("post_reset", 0, 0, 0, 24'h000000);
        compare_outs();

        // Start and one second of counting
        t0 = cyc;
        press(1, 0);
        chk("start_latency", 32'(t_run >= 0 && (t_run - t0) <= (D + 1) * TICK_CYC + 4), 32'd1);
        expect_st("started", m_ovf, 0, 1, to_bcd(m_cs));
        compare_outs();
        do_ticks(100 - m_cs);
        expect_st("one_second", 0, 0, 1, 24'h000100);
        compare_outs();

        // Lap freeze
        do_ticks(537 - m_cs);
        expect_st("at_0537", 0, 0, 1, 24'h000537);
        compare_outs();
        press(0, 1);
        expect_st("lap_on", 0, 1, 1, to_bcd(m_lap));
        compare_outs();
        saved = m_lap;
        do_ticks(30);
        expect_st("lap_frozen", 0, 1, 1, to_bcd(saved));
        compare_outs();
        press(0, 1);
        expect_st("lap_off_live", 0, 0, 1, to_bcd(m_cs));
        compare_outs();

        // Pause holds, then clear
        press(1, 0);
        expect_st("paused", 0, 0, 0, to_bcd(m_cs));
        compare_outs();
        saved = m_cs;
        do_ticks(50);
        expect_st("pause_hold", 0, 0, 0, to_bcd(saved));
        compare_outs();
        press(0, 1);
        m_cs = 0;
        m_ovf = 1'b0;
        expect_st("cleared", 0, 0, 0, 24'h000000);
        compare_outs();

        // Minute carry and wrap past MAXM:59.99
        press(1, 0);
        do_ticks(5999 - m_cs);
        expect_st("at_005999", 0, 0, 1, 24'h005999);
        compare_outs();
        do_ticks(1);
        expect_st("at_010000", 0, 0, 1, 24'h010000);
        compare_outs();
        do_ticks(11999 - m_cs);
        expect_st("at_015999", 0, 0, 1, 24'h015999);
        compare_outs();
        do_ticks(1);
        expect_st("wrap", 1, 0, 1, 24'h000000);
        compare_outs();

        // Bounce: single-sample glitches never reach the debounce count
        for (int i = 0; i < 3; i++) begin
            ss_n = 1'b0;
            do_ticks(1);
            ss_n = 1'b1;
            do_ticks(1);
        end
        do_ticks(D + 4);
        expect_st("bounce_ignored", m_ovf, 0, 1, to_bcd(m_cs));
        compare_outs();

        // Both keys together in RUN: start/stop wins
        press(1, 1);
        expect_st("both_keys", 1, 0, 0, to_bcd(m_cs));
        compare_outs();
        press(0, 1);
        m_cs = 0;
        m_ovf = 1'b0;
        expect_st("clear_after_both", 0, 0, 0, 24'h000000);
        compare_outs();

        // Asynchronous reset while in RUN_LAP
        press(1, 0);
        press(0, 1);
        expect_st("pre_async_lap", 0, 1, 1, to_bcd(m_lap));
        compare_outs();
        @(posedge clk);
        #5 rst_n = 1'b0;
        #1;
        expect_st("async_reset", 0, 0, 0, 24'h000000);
        compare_outs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        expect_st("after_async", 0, 0, 0, 24'h000000);
        compare_outs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
